// File: rtl/gen_raddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gen_raddr_ctrl
//  Purpose  : Read-address generator for a two-bank ping-pong row buffer.
//             Each full bank is swept 8 times (one sweep per bit plane),
//             row by row, and then released back to the writer.
//  Options  : GEN_RADDR_ROW_GAP_EN - when defined, inserts a 2-cycle gap
//             after every row except the last row of the final pass.
//  Revision : 1.0 - initial release
// ============================================================================
module gen_raddr_ctrl #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int ADDR_W = 7
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic [1:0]        BANK_FULL,
  input  logic              DOWN_READY,
  output logic [ADDR_W-1:0] RADDR,
  output logic              RD_EN,
  output logic              GEN_RADDR_START,
  output logic              GEN_RADDR_HSYNC,
  output logic [1:0]        BANK_RELEASE,
  output logic              BUSY
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_W-1:0] BANK_WORDS = ADDR_W'(ROWS * COLS);
  localparam logic [ADDR_W-1:0] ROW_WORDS  = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP   = 2'd1,
    GAP     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             bsel;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       pass;
  logic             col_last;
  logic             row_last;
  logic             pass_last;

`ifdef GEN_RADDR_ROW_GAP_EN
  logic             gap_cnt;
`endif

  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  assign pass_last = (pass == 3'd7);

  // Flat buffer address: bank base + row offset + column.
  assign RADDR = (bsel ? BANK_WORDS : '0) + ADDR_W'(row) * ROW_WORDS + ADDR_W'(col);

  // Next-state decode and per-cycle strobes; all outputs default low.
  always_comb begin
    state_next      = state;
    RD_EN           = 1'b0;
    GEN_RADDR_START = 1'b0;
    GEN_RADDR_HSYNC = 1'b0;
    BANK_RELEASE    = 2'b00;
    BUSY            = (state != IDLE);
    case (state)
      IDLE: begin
        // Only the bank the pointer selects may start a sweep.
        if (BANK_FULL[bsel]) state_next = SWEEP;
      end
      SWEEP: begin
        if (DOWN_READY) begin
          RD_EN           = 1'b1;
          GEN_RADDR_START = (row == '0) && (col == '0);
          GEN_RADDR_HSYNC = col_last;
          if (col_last && row_last && pass_last) begin
            state_next = RELEASE;
          end
`ifdef GEN_RADDR_ROW_GAP_EN
          else if (col_last) begin
            state_next = GAP;
          end
`endif
        end
      end
      GAP: begin
`ifdef GEN_RADDR_ROW_GAP_EN
        if (gap_cnt) state_next = SWEEP;
`else
        state_next = IDLE;
`endif
      end
      RELEASE: begin
        BANK_RELEASE = bsel ? 2'b10 : 2'b01;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus sweep counters; counters move only on a consumed address.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state <= IDLE;
      bsel  <= 1'b0;
      col   <= '0;
      row   <= '0;
      pass  <= 3'd0;
    end else begin
      state <= state_next;
      if (RD_EN) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row  <= '0;
            pass <= pass + 3'd1;  // 7 wraps to 0 at the end of the last plane
          end else begin
            row <= row + ROW_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (state == RELEASE) bsel <= ~bsel;
    end
  end

`ifdef GEN_RADDR_ROW_GAP_EN
  // Two-cycle gap timer: cleared outside GAP, toggles once inside it.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      gap_cnt <= 1'b0;
    end else begin
      gap_cnt <= (state == GAP) ? ~gap_cnt : 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gen_raddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gen_raddr_ctrl
//  Purpose  : Self-checking bench for gen_raddr_ctrl (COLS=4, ROWS=2, ADDR_W=5)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gen_raddr_ctrl;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int ADDR_W = 5;
  localparam int BANK_N = ROWS * COLS;
`ifdef GEN_RADDR_ROW_GAP_EN
  localparam int GAP_CYC = 2;
`else
  localparam int GAP_CYC = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        bf  = 2'b00;
  logic              dr  = 1'b0;
  logic [ADDR_W-1:0] raddr;
  logic              rd_en, start, hsync, busy;
  logic [1:0]        rel;

  int checks = 0;
  int errors = 0;

  gen_raddr_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .SYS_CLK         (clk),
    .SYS_RST         (rst),
    .BANK_FULL       (bf),
    .DOWN_READY      (dr),
    .RADDR           (raddr),
    .RD_EN           (rd_en),
    .GEN_RADDR_START (start),
    .GEN_RADDR_HSYNC (hsync),
    .BANK_RELEASE    (rel),
    .BUSY            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bf  = 2'b00;
    dr  = 1'b0;
    sample();
    chk("reset_raddr", raddr, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_release", rel, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  // Runs one bank to its release; checks address order, pulse counts and row spacing.
  task automatic run_bank(input int base, input logic [1:0] exp_rel, output int first_rd);
    int n_rd, n_st, n_hs, last_hs;
    logic [1:0] rel_seen;
    bit done;
    n_rd = 0; n_st = 0; n_hs = 0; last_hs = -1; rel_seen = 2'b00; done = 0;
    first_rd = -1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      sample();
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("sweep_addr", raddr, base + (n_rd % BANK_N));
        if (last_hs >= 0) begin
          chk("row_spacing", cyc - last_hs, GAP_CYC + 1);
          last_hs = -1;
        end
        if (start) begin
          n_st++;
          chk("start_addr", raddr % BANK_N, 0);
        end
        if (hsync) begin
          n_hs++;
          chk("hsync_col", raddr % COLS, COLS - 1);
          last_hs = cyc;
        end
        n_rd++;
      end
      if (rel != 2'b00) begin
        rel_seen = rel;
        done = 1;
        chk("release_after_last_hsync", cyc - last_hs, 1);
      end
      next_cycle();
    end
    if (!done) chk("release_timeout", 0, 1);
    chk("rd_en_count", n_rd, 8 * BANK_N);
    chk("start_count", n_st, 8);
    chk("hsync_count", n_hs, 8 * ROWS);
    chk("release_value", rel_seen, exp_rel);
  endtask

  typedef struct {
    logic [1:0]        bf;
    logic              dr;
    logic [ADDR_W-1:0] raddr;
    logic              rd;
    logic              st;
    logic              hs;
    logic [1:0]        rel;
    logic              busy;
  } vec_t;

  vec_t vecs [11];

  // Reference model state for the randomized run (transaction queue).
  typedef struct { int addr; bit st; bit hs; } ev_t;
  ev_t  q[$];
  int   mode;       // 0 waiting, 1 sweeping, 2 releasing
  int   exp_bank;
  int   gap_left;
  logic [1:0] wr_full;

  initial begin
    int first_rd;
    int starts;
    bit hit;

    // ---- table-driven opening sequence after reset ----
    vecs[0]  = '{2'b10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{2'b10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[4]  = '{2'b00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[5]  = '{2'b00, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[6]  = '{2'b00, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[7]  = '{2'b00, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[8]  = '{2'b00, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[9]  = '{2'b00, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};

    apply_reset();
    for (int i = 0; i < 11; i++) begin
      bf = vecs[i].bf;
      dr = vecs[i].dr;
      sample();
      chk($sformatf("vec%0d_raddr", i), raddr, vecs[i].raddr);
      chk($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].rd);
      chk($sformatf("vec%0d_start", i), start, vecs[i].st);
      chk($sformatf("vec%0d_hsync", i), hsync, vecs[i].hs);
      chk($sformatf("vec%0d_release", i), rel, vecs[i].rel);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      next_cycle();
    end

    // ---- single bank, downstream always ready ----
    apply_reset();
    bf = 2'b01; dr = 1'b1;
    run_bank(0, 2'b01, first_rd);
    chk("single_first_rd_latency", first_rd, 1);
    sample();
    chk("single_no_restart_busy", busy, 0);
    next_cycle();

    // ---- both banks full: bank 0, one idle cycle, bank 1 ----
    apply_reset();
    bf = 2'b11; dr = 1'b1;
    run_bank(0, 2'b01, first_rd);
    sample();
    chk("between_banks_busy", busy, 0);
    chk("between_banks_rd_en", rd_en, 0);
    next_cycle();
    run_bank(BANK_N, 2'b10, first_rd);
    chk("bank1_first_rd_latency", first_rd, 0);

    // ---- downstream stall at address 5 ----
    apply_reset();
    bf = 2'b01; dr = 1'b1;
    hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      sample();
      if (rd_en && raddr == 5'd4) hit = 1;
      next_cycle();
    end
    if (!hit) chk("stall_reach_timeout", 0, 1);
    dr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("stall_hold_raddr", raddr, 5);
      chk("stall_rd_en", rd_en, 0);
      next_cycle();
    end
    dr = 1'b1;
    for (int a = 5; a < 8; a++) begin
      sample();
      chk("stall_resume_rd_en", rd_en, 1);
      chk("stall_resume_raddr", raddr, a);
      next_cycle();
    end

    // ---- reset in the middle of pass 3 ----
    apply_reset();
    bf = 2'b01; dr = 1'b1;
    hit = 0; starts = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      sample();
      if (rd_en && start) starts++;
      if (rd_en && starts == 4 && raddr == 5'd6) hit = 1;
      else next_cycle();
    end
    if (!hit) chk("midreset_reach_timeout", 0, 1);
    rst = 1'b1;
    #1;
    chk("midreset_raddr", raddr, 0);
    chk("midreset_rd_en", rd_en, 0);
    chk("midreset_start", start, 0);
    chk("midreset_hsync", hsync, 0);
    chk("midreset_release", rel, 0);
    chk("midreset_busy", busy, 0);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("postreset_idle_busy", busy, 0);
    chk("postreset_release", rel, 0);
    next_cycle();
    sample();
    chk("postreset_rd_en", rd_en, 1);
    chk("postreset_raddr", raddr, 0);
    chk("postreset_start", start, 1);
    next_cycle();

    // ---- randomized writer / downstream against the transaction model ----
    apply_reset();
    mode = 0; exp_bank = 0; gap_left = 0; wr_full = 2'b00;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++)
        if (!wr_full[b] && $urandom_range(0, 7) == 0) wr_full[b] = 1'b1;
      bf = wr_full;
      if (mode != 0 && $urandom_range(0, 15) == 0) begin
        int fb;
        fb = int'($urandom_range(0, 1));
        bf[fb] = ~bf[fb];
      end
      dr = ($urandom_range(0, 3) != 0);
      sample();
      chk("rnd_busy", busy, (mode != 0) ? 1 : 0);
      if (mode == 0) begin
        chk("rnd_idle_rd_en", rd_en, 0);
        chk("rnd_idle_release", rel, 0);
        if (bf[exp_bank]) begin
          for (int p = 0; p < 8; p++)
            for (int r = 0; r < ROWS; r++)
              for (int cc = 0; cc < COLS; cc++)
                q.push_back('{exp_bank * BANK_N + r * COLS + cc,
                              (r == 0 && cc == 0), (cc == COLS - 1)});
          mode = 1;
        end
      end else if (mode == 1) begin
        chk("rnd_release_quiet", rel, 0);
        chk("rnd_raddr", raddr, q[0].addr);
        if (gap_left > 0) begin
          chk("rnd_gap_rd_en", rd_en, 0);
          gap_left--;
        end else begin
          chk("rnd_rd_en", rd_en, dr);
          if (dr) begin
            ev_t ev;
            ev = q.pop_front();
            chk("rnd_start", start, ev.st);
            chk("rnd_hsync", hsync, ev.hs);
            if (q.size() == 0) mode = 2;
            else if (ev.hs) gap_left = GAP_CYC;
          end
        end
      end else begin
        chk("rnd_release", rel, (exp_bank == 0) ? 2'b01 : 2'b10);
        chk("rnd_release_rd_en", rd_en, 0);
        exp_bank = 1 - exp_bank;
        mode = 0;
      end
      for (int b = 0; b < 2; b++)
        if (rel[b]) wr_full[b] = 1'b0;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
